// File: rtl/lsu_pkg.sv
// lsu_pkg: data width, funct3 size/sign encodings, fault-cause codes and the accept-time fault check
package lsu_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [1:0] C_NONE     = 2'd0;
  localparam logic [1:0] C_MISALIGN = 2'd1;
  localparam logic [1:0] C_ILLEGAL  = 2'd2;
  localparam logic [1:0] C_TIMEOUT  = 2'd3;
  function automatic logic [1:0] check(input logic rd, input logic wr, input logic [2:0] f3, input logic [1:0] off);
    logic ill, mis;
    ill = (rd && wr) || (wr ? f3 > 3'd2 : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7));
    mis = (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
    return ill ? C_ILLEGAL : mis ? C_MISALIGN : C_NONE;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the byte/halfword at off from word and sign/zero-extends it per funct3 (word, off, funct3 -> data)
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    data = funct3 == F3_B  ? {{24{b[7]}}, b} :
           funct3 == F3_H  ? {{16{h[15]}}, h} :
           funct3 == F3_W  ? word :
           funct3 == F3_BU ? {24'b0, b} :
           funct3 == F3_HU ? {16'b0, h} : '0;
  end
endmodule

// File: rtl/lsu.sv
// lsu: memory-stage load/store unit; execute request (req_valid/mem_read/mem_write/funct3/addr/wdata) -> dmem valid/ready bus -> one-cycle resp_valid with aligned rdata or fault/fault_cause, stall while busy
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [2:0]              funct3,
  input  logic [DATA_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    req_ready,
  output logic                    stall,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    fault,
  output logic [1:0]              fault_cause,
  output logic                    dmem_req_valid,
  input  logic                    dmem_req_ready,
  output logic                    dmem_we,
  output logic [DATA_WIDTH-1:0]   dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [DATA_WIDTH/8-1:0] dmem_wstrb,
  input  logic                    dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] word_q, aligned;
  logic [2:0] f3_q;
  logic [1:0] off_q, cause_q, cause_in;
  logic we_q, accept, timeout;
  assign accept = state == IDLE && req_valid && (mem_read || mem_write);
  assign cause_in = check(mem_read, mem_write, funct3, addr[1:0]);
  assign timeout = state == WAIT && !dmem_resp_valid && cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_n = state == IDLE ? (accept ? (cause_in != C_NONE ? RESP : REQ) : IDLE) :
              state == REQ  ? (dmem_req_ready ? WAIT : REQ) :
              state == WAIT ? (dmem_resp_valid || timeout ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      cause_q    <= C_NONE;
      word_q     <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q       <= mem_write;
        f3_q       <= funct3;
        off_q      <= addr[1:0];
        cause_q    <= cause_in;
        word_q     <= '0;
        dmem_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
        dmem_wdata <= funct3[1:0] == 2'd0 ? {4{wdata[7:0]}} : funct3[1:0] == 2'd1 ? {2{wdata[15:0]}} : wdata;
        dmem_wstrb <= !mem_write ? 4'b0000 : funct3[1:0] == 2'd0 ? 4'b0001 << addr[1:0] :
                      funct3[1:0] == 2'd1 ? 4'b0011 << addr[1:0] : 4'b1111;
      end
      if (state == REQ) cnt <= '0;
      if (state == WAIT) cnt <= cnt + 1'b1;
      if (state == WAIT && dmem_resp_valid) word_q <= dmem_rdata;
      if (timeout) cause_q <= C_TIMEOUT;
    end
  end
  lsu_load_align u_align (
    .word   (word_q),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (aligned)
  );
  assign req_ready      = state == IDLE;
  assign stall          = state == REQ || state == WAIT || accept;
  assign resp_valid     = state == RESP;
  assign fault          = resp_valid && cause_q != C_NONE;
  assign fault_cause    = resp_valid ? cause_q : C_NONE;
  assign rdata          = resp_valid && !fault && !we_q ? aligned : '0;
  assign dmem_req_valid = state == REQ;
  assign dmem_we        = state == REQ && we_q;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the memory stage. Takes one memory request per instruction from execute, performs the data-memory bus transaction with a valid/ready handshake, and returns load data already byte-lane-aligned and sign/zero-extended. That data is the `rdata` operand of the writeback mux. Misalignment, illegal size and bus timeout are reported as `fault` to the trap unit, which raises the writeback kill. The LSU stalls the pipeline while a transaction is outstanding.

## Interface

Parameters:
- `DATA_WIDTH`, `` `DATA_WIDTH `` (32): data and address width.
- `TIMEOUT`, 255: maximum number of cycles in WAIT before a bus-error fault.

Ports:
- Clocking and reset (already decided): one clock, `clk`; reset is `rst`, synchronous and active-high.
- `req_valid`  in  1  execute presents an operation.
- `mem_read`  in  1  load request.
- `mem_write`  in  1  store request.
- `funct3`  in  3  size/sign: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data from rs2.
- `req_ready`  out  1  high only in IDLE.
- `stall`  out  1  freezes upstream stages.
- `resp_valid`  out  1  one-cycle pulse; `rdata`/`fault` are valid.
- `rdata`  out  32  extended load data; 0 for stores and faults.
- `fault`  out  1  qualified by `resp_valid`.
- `fault_cause`  out  2  0=none, 1=misaligned, 2=illegal funct3, 3=bus timeout.
- `dmem_req_valid`  out  1  request valid.
- `dmem_req_ready`  in  1  request accepted.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_wstrb`  out  4  byte strobes.
- `dmem_resp_valid`  in  1  read data or write ack.
- `dmem_rdata`  in  32  word read data.

## Operation

- States: IDLE, REQ, WAIT, RESP.
- **IDLE**: accept when `req_valid && (mem_read || mem_write)`. Latch the operation inputs.
  - Both `mem_read` and `mem_write` set: treated as illegal funct3.
  - `req_valid` with neither set: ignored.
- **Faults checked at accept.** Illegal funct3 covers loads 3, 6, 7 and stores >2. Misaligned covers halfword with `addr[0]`≠0 and word with `addr[1:0]`≠0. On a fault go directly to RESP with the cause set; no bus access occurs.
- **REQ**: hold `dmem_req_valid` high with stable address, data and strobes until `dmem_req_ready`, then go to WAIT.
- **WAIT**: on `dmem_resp_valid`, capture the word and go to RESP.
  - Counter increments each WAIT cycle; it reaches `TIMEOUT` → RESP with cause 3.
  - A late response arriving in IDLE is dropped.
- **RESP**: assert `resp_valid` for one cycle, then go to IDLE.
- **Load alignment**: select byte/halfword at `addr[1:0]`. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- **Store lanes**:
  - SB: `wstrb` = 4'b0001<<`addr[1:0]`, byte replicated ×4.
  - SH: `wstrb` = 4'b0011<<`addr[1:0]`, halfword replicated ×2.
  - SW: `wstrb` = 4'b1111.

## Timing

- **Reset values**: state IDLE, counter 0. All outputs 0 except `req_ready`=1.
- **Reset mid-transaction**: abandon it; `dmem_req_valid` is low from the cycle after reset. The memory tolerates abandoned requests.
- **Latency**, request accepted at cycle T:
  - REQ starts at T+1.
  - Fault path: RESP at T+1.
  - `dmem_req_ready` high at T+1 and response at T+2: `resp_valid` at T+3.
- **`stall`**: = (state∈{REQ,WAIT}) || (state==IDLE && accept). It is low in RESP so the pipeline advances exactly when `resp_valid` is high.
- **`dmem_resp_valid` during REQ**: protocol violation, ignored.
- **Counter boundary**: `TIMEOUT`=255 reported at the 255th WAIT cycle. `dmem_resp_valid` in that same cycle wins (no fault).
- **Back-to-back**: the next request is accepted in the IDLE cycle after RESP, so throughput is at most one op per 4 cycles.

## Structure

- `defines.vh` holds `` `DATA_WIDTH ``, the funct3 load/store encodings and the fault-cause codes.
- State encoding is local to the module.
- One combinational sub-module, `lsu_load_align`: inputs (`dmem_rdata`, `addr[1:0]`, `funct3`), output the extended data.

## Test plan

- LB at addr 0x103, `dmem_rdata`=0x80FF_0000 → `rdata`=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH at 0x102, wdata=0x1234_ABCD → `dmem_wstrb`=4'b1100, `dmem_wdata`=0xABCD_ABCD, `dmem_addr`=0x100.
- LW at 0x101 → `resp_valid` at T+1, `fault`=1, cause 1, `dmem_req_valid` never asserted.
- `dmem_req_ready` held low 3 cycles, response 2 cycles later → `stall` high throughout, `resp_valid` exactly once, request fields stable.
- No response → cause 3 after 255 WAIT cycles; response on cycle 255 → normal completion.
- Reset asserted in WAIT → state IDLE, `dmem_req_valid`=0, `req_ready`=1 the next cycle; a subsequent LW completes normally.
